sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive port-0 grants while port 1 or 2 is pending.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 pN_req  in  1  (N=0..2) level request, held until pN_ack; port 0 = CPU, 1 = video/DMA, 2 = loader.
REQ-005 pN_we  in  1  1=write, 0=read; stable while pN_req high.
REQ-006 pN_word  in  1  1=16-bit access, 0=byte access.
REQ-007 pN_addr  in  25  byte address.
REQ-008 pN_din  in  16  write data.
REQ-009 pN_dout  out  16  read data, registered; updated only on a read ack to that port.
REQ-010 pN_ack  out  1  one-cycle completion pulse.
REQ-011 sd_addr/sd_din/sd_word  out  25/16/1  registered command fields to the SDRAM controller.
REQ-012 sd_rd, sd_wr  out  1  command strobes; controller is rising-edge triggered.
REQ-013 sd_dout  in  16  controller read data.
REQ-014 sd_ready  in  1  controller idle (low while busy).

Function
REQ-015 FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-016 IDLE: if any pN_req high and sd_ready high, select winner, latch its addr/din/word into sd_*, latch winner index, go ISSUE; otherwise stay.
REQ-017 Priority: port 0 wins unless starve counter == STARVE_LIMIT and port 1 or 2 pending.
REQ-018 Between ports 1 and 2: round-robin; last-granted of the pair gets lowest priority; initial preference port 1.
REQ-019 Starve counter: +1 per port-0 grant while port 1 or 2 req high; cleared on any port-1/2 grant or when neither pending; saturates at STARVE_LIMIT.
REQ-020 ISSUE: sd_rd (read) or sd_wr (write) high; held until sd_ready sampled low, then both deasserted and go WAIT.
REQ-021 sd_rd and sd_wr never both high; both low in IDLE and WAIT, guaranteeing a fresh rising edge per command.
REQ-022 WAIT: on sd_ready sampled high, for reads register sd_dout into winner's pN_dout; assert winner's pN_ack for one cycle; go IDLE.
REQ-023 pN_ack and pN_dout update occur in the same cycle; dout holds until next read ack to that port.
REQ-024 Arbitration in IDLE the cycle after ack; a port whose req stays high is treated as a new request.
REQ-025 Requests arriving during ISSUE/WAIT wait; no request is dropped while req stays high.
REQ-026 Requester dropping req before ack: in-flight transaction completes, ack still pulses.
REQ-027 sd_ready low in IDLE (controller initialising): no grant, no strobe.
REQ-028 Minimum latency req to ack: 4 cycles plus controller busy time.

Reset
REQ-029 Asynchronous reset: state IDLE, sd_rd=sd_wr=0, sd_addr/sd_din=0, sd_word=0, all pN_ack=0, all pN_dout=0, starve counter 0, round-robin pointer to port 1.
REQ-030 Reset mid-transaction abandons it without ack; first post-reset grant waits for sd_ready high.

Structure
REQ-031 Package sdram_arb_pkg holds state enum, NPORTS=3, port index type, and a command struct {we, word, addr, din}.
REQ-032 One sub-module sdram_arb_pick: combinational winner select from req vector, starve flag, RR pointer.

Verification
REQ-033 Bench model of controller: edge-triggered accept, busy 6 cycles, sd_ready low while busy, returns programmed data.
REQ-034 p0 read addr 0x000100, model data 0xBEEF -> single sd_rd pulse, p0_ack once, p0_dout=0xBEEF.
REQ-035 p1 and p2 requests held high continuously, p0 idle -> grants alternate 1,2,1,2.
REQ-036 p0,p1 held high, STARVE_LIMIT=4 -> grants 0,0,0,0,1,0,0,0,0,1.
REQ-037 p2 byte write addr 0x0000005, din 0x0042 -> sd_wr with sd_word=0, sd_addr=0x0000005, p2_dout unchanged.
REQ-038 Reset asserted during WAIT -> no ack, sd_rd/sd_wr low immediately; next request served normally after sd_ready high.
REQ-039 sd_ready held low 100 cycles with p0_req high -> no strobe until sd_ready high, then normal completion.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the three-port SDRAM arbiter.
// State encoding, port index and command bundle.
package sdram_arb_pkg;

  localparam int NPORTS = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef logic [1:0] port_t;

  typedef struct packed {
    logic        we;
    logic        word;
    logic [24:0] addr;
    logic [15:0] din;
  } cmd_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner select for the SDRAM arbiter.
// Port 0 first unless starved; ports 1/2 round-robin.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              starve,
  input  logic              rr_pref,
  output logic              gnt,
  output port_t             win
);

  logic other;
  logic p0_win;

  assign other  = req[1] | req[2];
  assign p0_win = req[0] & ~(starve & other);
  assign gnt    = |req;

  // rr_pref=1 means port 1 was last served, so port 2 goes first
  always_comb begin
    win = 2'd0;
    unique case (1'b1)
      p0_win:
        win = 2'd0;
      !p0_win && req[1] && (!req[2] || !rr_pref):
        win = 2'd1;
      !p0_win && req[2] && (!req[1] || rr_pref):
        win = 2'd2;
      default:
        win = 2'd0;
    endcase
  end

endmodule

// File: rtl/sdram_arb.sv
// Three-port arbiter in front of a single-command SDRAM controller.
// One transaction in flight; strobes return low between commands.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_word,
  input  logic [24:0] p0_addr,
  input  logic [15:0] p0_din,
  output logic [15:0] p0_dout,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_word,
  input  logic [24:0] p1_addr,
  input  logic [15:0] p1_din,
  output logic [15:0] p1_dout,
  output logic        p1_ack,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic        p2_word,
  input  logic [24:0] p2_addr,
  input  logic [15:0] p2_din,
  output logic [15:0] p2_dout,
  output logic        p2_ack,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_din,
  output logic        sd_word,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic [15:0] sd_dout,
  input  logic        sd_ready
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_t            state;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] ack_q;
  logic [15:0]       dout_q [NPORTS];
  cmd_t              cmd [NPORTS];
  cmd_t              sel;
  port_t             win;
  port_t             win_q;
  logic              gnt;
  logic              we_q;
  logic              rr_pref;
  logic              starve;
  logic              pend12;
  logic [CW-1:0]     cnt;

  assign req    = {p2_req, p1_req, p0_req};
  assign pend12 = p1_req | p2_req;
  assign starve = (cnt == CW'(STARVE_LIMIT));

  assign cmd[0] = '{we: p0_we, word: p0_word,
                    addr: p0_addr, din: p0_din};
  assign cmd[1] = '{we: p1_we, word: p1_word,
                    addr: p1_addr, din: p1_din};
  assign cmd[2] = '{we: p2_we, word: p2_word,
                    addr: p2_addr, din: p2_din};
  assign sel    = cmd[win];

  assign p0_ack  = ack_q[0];
  assign p1_ack  = ack_q[1];
  assign p2_ack  = ack_q[2];
  assign p0_dout = dout_q[0];
  assign p1_dout = dout_q[1];
  assign p2_dout = dout_q[2];

  sdram_arb_pick u_pick (
    .req     (req),
    .starve  (starve),
    .rr_pref (rr_pref),
    .gnt     (gnt),
    .win     (win)
  );

  // Grant, issue, wait-for-completion sequencer with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      sd_addr <= '0;
      sd_din  <= '0;
      sd_word <= 1'b0;
      we_q    <= 1'b0;
      win_q   <= '0;
      ack_q   <= '0;
      for (int i = 0; i < NPORTS; i++)
        dout_q[i] <= '0;
      cnt     <= '0;
      rr_pref <= 1'b0;
    end else begin
      ack_q <= '0;
      if (!pend12)
        cnt <= '0;
      unique case (state)
        IDLE: begin
          if (gnt && sd_ready) begin
            sd_addr <= sel.addr;
            sd_din  <= sel.din;
            sd_word <= sel.word;
            we_q    <= sel.we;
            sd_rd   <= ~sel.we;
            sd_wr   <= sel.we;
            win_q   <= win;
            state   <= ISSUE;
            if (win == 2'd0) begin
              if (pend12 && !starve)
                cnt <= cnt + CW'(1);
            end else begin
              cnt     <= '0;
              rr_pref <= (win == 2'd1);
            end
          end
        end
        ISSUE: begin
          if (!sd_ready) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (sd_ready) begin
            ack_q[win_q] <= 1'b1;
            if (!we_q)
              dout_q[win_q] <= sd_dout;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb with a busy-6 controller model.
// Stimulus pushes expected commands/acks; monitors pop and compare.
module tb_sdram_arb;

  typedef struct packed {
    logic        we;
    logic        word;
    logic [24:0] addr;
    logic [15:0] din;
  } cmd_e;

  typedef struct packed {
    logic [1:0]  port;
    logic [15:0] dout;
  } ack_e;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [2:0]  word = '0;
  logic [2:0]  hold = '0;
  logic [24:0] addr [3];
  logic [15:0] din [3];
  logic [15:0] p0_dout, p1_dout, p2_dout;
  logic        p0_ack, p1_ack, p2_ack;
  logic [24:0] sd_addr;
  logic [15:0] sd_din;
  logic [15:0] sd_dout = '0;
  logic        sd_word, sd_rd, sd_wr, sd_ready;
  logic [2:0]  ackv;
  logic [15:0] doutv [3];

  int   busy = 0;
  logic init_hold = 1'b0;
  logic rd_q = 1'b0;
  logic wr_q = 1'b0;

  int   n_chk = 0;
  int   n_pass = 0;
  cmd_e cmd_q [$];
  ack_e ack_q [$];
  logic [15:0] shadow [3];

  assign ackv = {p2_ack, p1_ack, p0_ack};
  assign doutv[0] = p0_dout;
  assign doutv[1] = p1_dout;
  assign doutv[2] = p2_dout;
  assign sd_ready = (busy == 0) && !init_hold;

  always #5 clk = ~clk;

  sdram_arb #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .p0_req   (req[0]),
    .p0_we    (we[0]),
    .p0_word  (word[0]),
    .p0_addr  (addr[0]),
    .p0_din   (din[0]),
    .p0_dout  (p0_dout),
    .p0_ack   (p0_ack),
    .p1_req   (req[1]),
    .p1_we    (we[1]),
    .p1_word  (word[1]),
    .p1_addr  (addr[1]),
    .p1_din   (din[1]),
    .p1_dout  (p1_dout),
    .p1_ack   (p1_ack),
    .p2_req   (req[2]),
    .p2_we    (we[2]),
    .p2_word  (word[2]),
    .p2_addr  (addr[2]),
    .p2_din   (din[2]),
    .p2_dout  (p2_dout),
    .p2_ack   (p2_ack),
    .sd_addr  (sd_addr),
    .sd_din   (sd_din),
    .sd_word  (sd_word),
    .sd_rd    (sd_rd),
    .sd_wr    (sd_wr),
    .sd_dout  (sd_dout),
    .sd_ready (sd_ready)
  );

  function automatic logic [15:0] model_data(logic [24:0] a);
    if (a == 25'h100)
      return 16'hBEEF;
    return {a[7:0], ~a[7:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic set_port(int p, logic w, logic wd,
                          logic [24:0] a, logic [15:0] d);
    we[p]   = w;
    word[p] = wd;
    addr[p] = a;
    din[p]  = d;
  endtask

  task automatic push(int p, logic w, logic wd,
                      logic [24:0] a, logic [15:0] d);
    ack_e e;
    cmd_q.push_back('{we: w, word: wd, addr: a, din: d});
    if (!w)
      shadow[p] = model_data(a);
    e.port = 2'(p);
    e.dout = shadow[p];
    ack_q.push_back(e);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((ack_q.size() != 0 || cmd_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ack_q.size() != 0 || cmd_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d acks %0d cmds pending, required 0",
               ack_q.size(), cmd_q.size());
      ack_q.delete();
      cmd_q.delete();
    end
  endtask

  // Controller model: accepts on a strobe rising edge, busy 6 cycles
  always @(posedge clk) begin
    rd_q <= sd_rd;
    wr_q <= sd_wr;
    if (busy != 0)
      busy <= busy - 1;
    else if (sd_ready && ((sd_rd && !rd_q) || (sd_wr && !wr_q))) begin
      busy <= 6;
      if (sd_rd)
        sd_dout <= model_data(sd_addr);
    end
  end

  // Command and ack monitor
  initial begin : monitor
    logic prd, pwr;
    cmd_e c;
    ack_e e;
    prd = 1'b0;
    pwr = 1'b0;
    forever begin
      @(negedge clk);
      if ((sd_rd && !prd) || (sd_wr && !pwr)) begin
        chk("sd_excl", 32'(sd_rd & sd_wr), 32'd0);
        if (cmd_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_cmd: got addr %h, required none", sd_addr);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_we", 32'(sd_wr), 32'(c.we));
          chk("cmd_word", 32'(sd_word), 32'(c.word));
          chk("cmd_addr", 32'(sd_addr), 32'(c.addr));
          chk("cmd_din", 32'(sd_din), 32'(c.din));
        end
      end
      prd = sd_rd;
      pwr = sd_wr;
      for (int i = 0; i < 3; i++) begin
        if (ackv[i]) begin
          if (ack_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_ack: got port %0d, required none", i);
          end else begin
            e = ack_q.pop_front();
            chk("ack_port", 32'(i), 32'(e.port));
            chk("ack_dout", 32'(doutv[i]), 32'(e.dout));
          end
        end
      end
    end
  end

  // Requesters drop req on their ack unless held
  initial begin : dropper
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (ackv[i] && !hold[i])
          req[i] = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin : stim
    int   n;
    logic seen;
    for (int i = 0; i < 3; i++) begin
      addr[i]   = '0;
      din[i]    = '0;
      shadow[i] = '0;
    end
    #1 reset = 1'b1;
    #1;
    chk("rst_strobe", 32'({sd_rd, sd_wr, sd_word}), 32'd0);
    chk("rst_addr", 32'(sd_addr), 32'd0);
    chk("rst_din", 32'(sd_din), 32'd0);
    chk("rst_ack", 32'(ackv), 32'd0);
    chk("rst_dout", 32'(p0_dout | p1_dout | p2_dout), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // p1/p2 held high: alternate starting with port 1
    set_port(1, 1'b0, 1'b1, 25'h210, 16'h0);
    set_port(2, 1'b0, 1'b1, 25'h320, 16'h0);
    hold = 3'b110;
    push(1, 1'b0, 1'b1, 25'h210, 16'h0);
    push(2, 1'b0, 1'b1, 25'h320, 16'h0);
    push(1, 1'b0, 1'b1, 25'h210, 16'h0);
    push(2, 1'b0, 1'b1, 25'h320, 16'h0);
    req = 3'b110;
    drain(300);
    req  = 3'b000;
    hold = 3'b000;

    // p2 byte write: dout must keep the last read value
    set_port(2, 1'b1, 1'b0, 25'h0000005, 16'h0042);
    push(2, 1'b1, 1'b0, 25'h0000005, 16'h0042);
    req[2] = 1'b1;
    drain(100);

    // p0 single read
    set_port(0, 1'b0, 1'b1, 25'h000100, 16'h0);
    push(0, 1'b0, 1'b1, 25'h000100, 16'h0);
    req[0] = 1'b1;
    drain(100);
    repeat (3) @(negedge clk);
    chk("p0_dout_hold", 32'(p0_dout), 32'h0000BEEF);

    // p0/p1 held: starvation limit gives 0,0,0,0,1 twice
    set_port(0, 1'b0, 1'b1, 25'h000100, 16'h0);
    set_port(1, 1'b0, 1'b1, 25'h000210, 16'h0);
    hold = 3'b011;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++)
        push(0, 1'b0, 1'b1, 25'h000100, 16'h0);
      push(1, 1'b0, 1'b1, 25'h000210, 16'h0);
    end
    req = 3'b011;
    drain(600);
    req  = 3'b000;
    hold = 3'b000;

    // reset while waiting for the controller
    set_port(0, 1'b0, 1'b1, 25'h000040, 16'h0);
    cmd_q.push_back('{we: 1'b0, word: 1'b1, addr: 25'h40, din: 16'h0});
    req[0] = 1'b1;
    n = 0;
    while (sd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ctrl_busy", 32'(sd_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_strobe", 32'({sd_rd, sd_wr}), 32'd0);
    chk("mid_rst_ack", 32'(ackv), 32'd0);
    chk("mid_rst_dout", 32'(p0_dout), 32'd0);
    req = 3'b000;
    for (int i = 0; i < 3; i++)
      shadow[i] = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // controller not ready for 100 cycles, then 0, 1, 2
    init_hold = 1'b1;
    set_port(0, 1'b1, 1'b1, 25'h0000ABC, 16'h1234);
    set_port(1, 1'b0, 1'b1, 25'h0000210, 16'h0);
    set_port(2, 1'b0, 1'b1, 25'h0000320, 16'h0);
    push(0, 1'b1, 1'b1, 25'h0000ABC, 16'h1234);
    push(1, 1'b0, 1'b1, 25'h0000210, 16'h0);
    push(2, 1'b0, 1'b1, 25'h0000320, 16'h0);
    req  = 3'b111;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen = seen | sd_rd | sd_wr | (|ackv);
    end
    chk("not_ready_idle", 32'(seen), 32'd0);
    init_hold = 1'b0;
    drain(300);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
